// File: rtl/psram_ctrl.sv
// rtl/psram_ctrl.sv - PSRAM command/address/latency/data sequencer with registered PHY outputs
module psram_ctrl #(
  parameter int         BIT_WIDTH = 16,
  parameter int         LATENCY   = 6,
  parameter int         RD_DLY    = 2,
  parameter logic [7:0] RD_CMD    = 8'h20,
  parameter logic [7:0] WR_CMD    = 8'hA0
) (
  input  logic                 ram_clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [31:0]          req_addr,
  input  logic [7:0]           req_len,
  input  logic [BIT_WIDTH-1:0] wr_data_hi,
  input  logic [BIT_WIDTH-1:0] wr_data_lo,
  output logic                 wr_data_ready,
  output logic [BIT_WIDTH-1:0] rd_data_hi,
  output logic [BIT_WIDTH-1:0] rd_data_lo,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 psram_clk,
  output logic                 psram_ce,
  output logic                 dq_en,
  output logic [BIT_WIDTH-1:0] dq_out_hi,
  output logic [BIT_WIDTH-1:0] dq_out_lo,
  input  logic [BIT_WIDTH-1:0] dq_in_hi,
  input  logic [BIT_WIDTH-1:0] dq_in_lo,
  output logic                 dm_en,
  output logic [1:0]           dm_out_hi,
  output logic [1:0]           dm_out_lo
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, LAT, DATA, END} state_t;

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           lat_cnt_q, lat_cnt_d;
  logic [7:0]           data_cnt_q, data_cnt_d;
  logic [RD_DLY-1:0]    rd_pipe_q, rd_pipe_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_data_ready_q, wr_data_ready_d;
  logic                 psram_clk_q, psram_clk_d;
  logic                 psram_ce_q, psram_ce_d;
  logic                 dq_en_q, dq_en_d;
  logic                 dm_en_q, dm_en_d;
  logic [BIT_WIDTH-1:0] dq_out_hi_q, dq_out_hi_d;
  logic [BIT_WIDTH-1:0] dq_out_lo_q, dq_out_lo_d;
  logic [1:0]           dm_out_hi_q, dm_out_hi_d;
  logic [1:0]           dm_out_lo_q, dm_out_lo_d;
  logic [BIT_WIDTH-1:0] rd_data_hi_q, rd_data_hi_d;
  logic [BIT_WIDTH-1:0] rd_data_lo_q, rd_data_lo_d;
  logic                 active_d;
  logic                 wr_phase_d;
  logic                 rd_now;
  logic [7:0]           cmd_byte;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    lat_cnt_d  = lat_cnt_q;
    data_cnt_d = data_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = CMD;
          wr_d    = req_wr;
          addr_d  = req_addr;
          len_d   = req_len;
        end
      end
      CMD:  state_d = ADDR;
      ADDR: begin
        state_d   = LAT;
        lat_cnt_d = 8'(LATENCY - 1);
      end
      LAT: begin
        if (lat_cnt_q == 8'd0) begin
          state_d    = DATA;
          data_cnt_d = 8'd0;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      DATA: begin
        if (data_cnt_q == len_q) state_d = END;
        else                     data_cnt_d = data_cnt_q + 8'd1;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so each lands in a flop aligned with its cycle.
    active_d        = (state_d == CMD) || (state_d == ADDR) || (state_d == LAT) || (state_d == DATA);
    wr_phase_d      = (state_d == DATA) && wr_d;
    req_ready_d     = (state_d == IDLE);
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == END);
    psram_ce_d      = !active_d;
    psram_clk_d     = active_d;
    dq_en_d         = (state_d == CMD) || (state_d == ADDR) || wr_phase_d;
    dm_en_d         = wr_phase_d;
    dm_out_hi_d     = 2'b00;
    dm_out_lo_d     = 2'b00;
    wr_data_ready_d = wr_d && (((state_d == LAT) && (lat_cnt_d == 8'd0)) ||
                               ((state_d == DATA) && (data_cnt_d != len_d)));
    cmd_byte        = wr_d ? WR_CMD : RD_CMD;
    dq_out_hi_d     = '0;
    dq_out_lo_d     = '0;
    if (state_d == CMD) begin
      dq_out_hi_d = BIT_WIDTH'({(BIT_WIDTH/8){cmd_byte}});
      dq_out_lo_d = BIT_WIDTH'({(BIT_WIDTH/8){cmd_byte}});
    end else if (state_d == ADDR) begin
      dq_out_hi_d = BIT_WIDTH'(addr_d[31:16]);
      dq_out_lo_d = BIT_WIDTH'(addr_d[15:0]);
    end else if (wr_phase_d) begin
      dq_out_hi_d = wr_data_hi;
      dq_out_lo_d = wr_data_lo;
    end

    // Bit k of the pipe marks a read DATA cycle k+1 cycles ago; the top bit is rd_valid.
    rd_now       = (state_q == DATA) && !wr_q;
    rd_pipe_d    = (rd_pipe_q << 1) | RD_DLY'(rd_now);
    rd_data_hi_d = rd_data_hi_q;
    rd_data_lo_d = rd_data_lo_q;
    if (rd_pipe_d[RD_DLY-1]) begin
      rd_data_hi_d = dq_in_hi;
      rd_data_lo_d = dq_in_lo;
    end
  end

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      len_q           <= '0;
      lat_cnt_q       <= '0;
      data_cnt_q      <= '0;
      rd_pipe_q       <= '0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      wr_data_ready_q <= 1'b0;
      psram_clk_q     <= 1'b0;
      psram_ce_q      <= 1'b1;
      dq_en_q         <= 1'b0;
      dm_en_q         <= 1'b0;
      dq_out_hi_q     <= '0;
      dq_out_lo_q     <= '0;
      dm_out_hi_q     <= '0;
      dm_out_lo_q     <= '0;
      rd_data_hi_q    <= '0;
      rd_data_lo_q    <= '0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      lat_cnt_q       <= lat_cnt_d;
      data_cnt_q      <= data_cnt_d;
      rd_pipe_q       <= rd_pipe_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      wr_data_ready_q <= wr_data_ready_d;
      psram_clk_q     <= psram_clk_d;
      psram_ce_q      <= psram_ce_d;
      dq_en_q         <= dq_en_d;
      dm_en_q         <= dm_en_d;
      dq_out_hi_q     <= dq_out_hi_d;
      dq_out_lo_q     <= dq_out_lo_d;
      dm_out_hi_q     <= dm_out_hi_d;
      dm_out_lo_q     <= dm_out_lo_d;
      rd_data_hi_q    <= rd_data_hi_d;
      rd_data_lo_q    <= rd_data_lo_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_data_ready = wr_data_ready_q;
  assign rd_valid      = rd_pipe_q[RD_DLY-1];
  assign rd_data_hi    = rd_data_hi_q;
  assign rd_data_lo    = rd_data_lo_q;
  assign psram_clk     = psram_clk_q;
  assign psram_ce      = psram_ce_q;
  assign dq_en         = dq_en_q;
  assign dq_out_hi     = dq_out_hi_q;
  assign dq_out_lo     = dq_out_lo_q;
  assign dm_en         = dm_en_q;
  assign dm_out_hi     = dm_out_hi_q;
  assign dm_out_lo     = dm_out_lo_q;

endmodule
